// File: rtl/ram_bist_pkg.sv
// Shared types for the March C- RAM BIST controller.
// RAM_BIST_STOP_ON_FAIL_EN (see ram_bist_ctrl) ends the test on first mismatch.
package ram_bist_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DRAIN,
        S_DONE
    } state_e;

    typedef enum logic {
        OP_READ,
        OP_WRITE
    } op_e;

    localparam int MARCH_ELEMS = 6;

    typedef struct packed {
        logic down;
        op_e  first_op;
        logic two_op;
        logic rd_val;
        logic wr_val;
    } elem_t;

    localparam elem_t M0 = '{1'b0, OP_WRITE, 1'b0, 1'b0, 1'b0};
    localparam elem_t M1 = '{1'b0, OP_READ,  1'b1, 1'b0, 1'b1};
    localparam elem_t M2 = '{1'b0, OP_READ,  1'b1, 1'b1, 1'b0};
    localparam elem_t M3 = '{1'b1, OP_READ,  1'b1, 1'b0, 1'b1};
    localparam elem_t M4 = '{1'b1, OP_READ,  1'b1, 1'b1, 1'b0};
    localparam elem_t M5 = '{1'b0, OP_READ,  1'b0, 1'b0, 1'b0};

    function automatic elem_t march_elem(input logic [2:0] idx);
        case (idx)
            3'd0:    return M0;
            3'd1:    return M1;
            3'd2:    return M2;
            3'd3:    return M3;
            3'd4:    return M4;
            default: return M5;
        endcase
    endfunction

endpackage

// File: rtl/ram_bist_if.sv
// RAM-side bus driven by the BIST controller.
// Master drives the RAM; slave is the RAM itself.
interface ram_bist_if #(
    parameter int ADDR_WIDTH = 6,
    parameter int DATA_WIDTH = 8
);
    logic [DATA_WIDTH-1:0] data_in;
    logic [DATA_WIDTH-1:0] data_out;
    logic                  write_enb;
    logic                  read_enb;
    logic [ADDR_WIDTH-1:0] address;

    modport master (
        output data_in,
        output write_enb,
        output read_enb,
        output address,
        input  data_out
    );

    modport slave (
        input  data_in,
        input  write_enb,
        input  read_enb,
        input  address,
        output data_out
    );
endinterface

// File: rtl/ram_bist_addr_gen.sv
// Up/down address counter for the march walk.
// Clear and load-to-terminal reposition it at element boundaries.
module ram_bist_addr_gen #(
    parameter int ADDR_WIDTH = 6
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic                  i_clr,
    input  logic                  i_load_top,
    input  logic                  i_step,
    input  logic                  i_down,
    output logic [ADDR_WIDTH-1:0] o_addr,
    output logic                  o_last
);
    logic [ADDR_WIDTH-1:0] r_addr;

    always_ff @(posedge i_clk) begin
        if (i_reset || i_clr)
            r_addr <= '0;
        else if (i_load_top)
            r_addr <= '1;
        else if (i_step)
            r_addr <= i_down ? r_addr - 1'b1 : r_addr + 1'b1;
    end

    assign o_addr = r_addr;
    assign o_last = i_down ? (r_addr == '0) : (r_addr == '1);
endmodule

// File: rtl/ram_bist_ctrl.sv
// March C- BIST controller driving a RAM and checking its read data.
// Define RAM_BIST_STOP_ON_FAIL_EN to stop issuing ops at the first mismatch.
module ram_bist_ctrl
    import ram_bist_pkg::*;
#(
    parameter int ADDR_WIDTH = 6,
    parameter int DATA_WIDTH = 8,
    parameter int READ_LAT   = 1
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic                  i_start,
    ram_bist_if.master            io_ram,
    output logic                  o_busy,
    output logic                  o_done,
    output logic                  o_pass,
    output logic [ADDR_WIDTH-1:0] o_fail_addr,
    output logic [2:0]            o_fail_elem,
    output logic [DATA_WIDTH-1:0] o_fail_data
);
`ifdef RAM_BIST_STOP_ON_FAIL_EN
    localparam bit STOP_ON_FAIL = 1'b1;
`else
    localparam bit STOP_ON_FAIL = 1'b0;
`endif
    localparam logic [2:0] LAST_ELEM  = 3'(MARCH_ELEMS - 1);
    localparam logic [2:0] DRAIN_LAST = 3'(READ_LAT - 1);

    state_e                r_state, w_state_nxt;
    logic [2:0]            r_elem, w_elem_nxt;
    logic                  r_phase, w_phase_nxt;
    logic [2:0]            r_drain, w_drain_nxt;
    logic                  w_adv, w_clr, w_load, w_step, w_last;
    logic [ADDR_WIDTH-1:0] w_addr;
    logic                  w_accept, w_mis, w_run_nxt, w_op_wr;
    logic                  w_cur_down, w_cur_two, w_cur_rd;
    logic                  w_we_nxt, w_re_nxt;
    logic [DATA_WIDTH-1:0] w_din_nxt;
    logic                  r_we, r_re, r_ok;
    logic [DATA_WIDTH-1:0] r_din;

    logic                  r_pv    [READ_LAT];
    logic                  r_pexp  [READ_LAT];
    logic [ADDR_WIDTH-1:0] r_paddr [READ_LAT];
    logic [2:0]            r_pelem [READ_LAT];

    assign w_cur_down = march_elem(r_elem).down;
    assign w_cur_two  = march_elem(r_elem).two_op;
    assign w_cur_rd   = march_elem(r_elem).rd_val;
    assign w_accept   = i_start && (r_state == S_IDLE || r_state == S_DONE);
    assign w_mis      = r_pv[READ_LAT-1] &&
        (io_ram.data_out != {DATA_WIDTH{r_pexp[READ_LAT-1]}});

    ram_bist_addr_gen #(.ADDR_WIDTH(ADDR_WIDTH)) u_addr (
        .i_clk      (i_clk),
        .i_reset    (i_reset),
        .i_clr      (w_clr),
        .i_load_top (w_load),
        .i_step     (w_step),
        .i_down     (w_cur_down),
        .o_addr     (w_addr),
        .o_last     (w_last)
    );

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= S_IDLE;
            r_elem  <= '0;
            r_phase <= 1'b0;
            r_drain <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_elem  <= w_elem_nxt;
            r_phase <= w_phase_nxt;
            r_drain <= w_drain_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_elem_nxt  = r_elem;
        w_phase_nxt = r_phase;
        w_drain_nxt = r_drain;
        w_adv       = 1'b0;
        w_step      = 1'b0;
        unique case (r_state)
            S_IDLE, S_DONE: begin
                if (i_start) begin
                    w_state_nxt = S_RUN;
                    w_elem_nxt  = '0;
                    w_phase_nxt = 1'b0;
                end
            end
            S_RUN: begin
                if (STOP_ON_FAIL && w_mis) begin
                    w_state_nxt = S_DRAIN;
                    w_drain_nxt = '0;
                end else if (w_cur_two && !r_phase) begin
                    w_phase_nxt = 1'b1;
                end else begin
                    w_phase_nxt = 1'b0;
                    if (!w_last) begin
                        w_step = 1'b1;
                    end else if (r_elem == LAST_ELEM) begin
                        w_state_nxt = S_DRAIN;
                        w_drain_nxt = '0;
                    end else begin
                        w_elem_nxt = r_elem + 3'd1;
                        w_adv      = 1'b1;
                    end
                end
            end
            S_DRAIN: begin
                if (r_drain == DRAIN_LAST)
                    w_state_nxt = S_DONE;
                else
                    w_drain_nxt = r_drain + 3'd1;
            end
            default: w_state_nxt = S_IDLE;
        endcase

        // Outputs are registered, so they are computed from the next op.
        w_run_nxt = (w_state_nxt == S_RUN);
        w_load    = w_adv && march_elem(w_elem_nxt).down;
        w_clr     = !w_run_nxt || (w_adv && !march_elem(w_elem_nxt).down);
        w_op_wr   = w_phase_nxt ||
            (march_elem(w_elem_nxt).first_op == OP_WRITE);
        w_we_nxt  = w_run_nxt && w_op_wr;
        w_re_nxt  = w_run_nxt && !w_op_wr;
        w_din_nxt = w_we_nxt ?
            {DATA_WIDTH{march_elem(w_elem_nxt).wr_val}} : '0;
    end

    always_ff @(posedge i_clk) begin
        if (i_reset || w_accept) begin
            for (int i = 0; i < READ_LAT; i++) begin
                r_pv[i]    <= 1'b0;
                r_pexp[i]  <= 1'b0;
                r_paddr[i] <= '0;
                r_pelem[i] <= '0;
            end
        end else begin
            r_pv[0]    <= r_re;
            r_pexp[0]  <= w_cur_rd;
            r_paddr[0] <= w_addr;
            r_pelem[0] <= r_elem;
            for (int i = 1; i < READ_LAT; i++) begin
                r_pv[i]    <= r_pv[i-1];
                r_pexp[i]  <= r_pexp[i-1];
                r_paddr[i] <= r_paddr[i-1];
                r_pelem[i] <= r_pelem[i-1];
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_we        <= 1'b0;
            r_re        <= 1'b0;
            r_din       <= '0;
            r_ok        <= 1'b0;
            o_busy      <= 1'b0;
            o_done      <= 1'b0;
            o_pass      <= 1'b0;
            o_fail_addr <= '0;
            o_fail_elem <= '0;
            o_fail_data <= '0;
        end else begin
            r_we   <= w_we_nxt;
            r_re   <= w_re_nxt;
            r_din  <= w_din_nxt;
            o_busy <= w_run_nxt || (w_state_nxt == S_DRAIN);
            if (w_accept) begin
                r_ok        <= 1'b1;
                o_done      <= 1'b0;
                o_pass      <= 1'b0;
                o_fail_addr <= '0;
                o_fail_elem <= '0;
                o_fail_data <= '0;
            end else begin
                if (w_mis && r_ok) begin
                    r_ok        <= 1'b0;
                    o_fail_addr <= r_paddr[READ_LAT-1];
                    o_fail_elem <= r_pelem[READ_LAT-1];
                    o_fail_data <= io_ram.data_out;
                end
                if (r_state == S_DRAIN && w_state_nxt == S_DONE) begin
                    o_done <= 1'b1;
                    o_pass <= r_ok && !w_mis;
                end
            end
        end
    end

    assign io_ram.data_in   = r_din;
    assign io_ram.write_enb = r_we;
    assign io_ram.read_enb  = r_re;
    assign io_ram.address   = w_addr;
endmodule

// File: tb/tb_ram_bist_ctrl.sv
// Bench for ram_bist_ctrl: behavioural RAMs with injectable stuck-at faults,
// an op-list March C- model, vector table, random faults and corner sequences.
module tb_ram_bist_ctrl;
    localparam int AW = 6;
    localparam int DW = 8;
    localparam int N  = 64;
`ifdef RAM_BIST_STOP_ON_FAIL_EN
    localparam bit STOP = 1'b1;
`else
    localparam bit STOP = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst, start1, start3;
    int   sel;
    int   n_chk = 0;
    int   n_fail = 0;

    bit f_en;
    int f_addr, f_bit;
    bit f_sa;

    ram_bist_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) b1 ();
    ram_bist_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) b3 ();

    logic          busy1, done1, pass1, busy3, done3, pass3;
    logic [AW-1:0] fa1, fa3;
    logic [2:0]    fe1, fe3;
    logic [DW-1:0] fd1, fd3;

    ram_bist_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .READ_LAT(1)) u1 (
        .i_clk(clk), .i_reset(rst), .i_start(start1), .io_ram(b1),
        .o_busy(busy1), .o_done(done1), .o_pass(pass1),
        .o_fail_addr(fa1), .o_fail_elem(fe1), .o_fail_data(fd1)
    );

    ram_bist_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .READ_LAT(3)) u3 (
        .i_clk(clk), .i_reset(rst), .i_start(start3), .io_ram(b3),
        .o_busy(busy3), .o_done(done3), .o_pass(pass3),
        .o_fail_addr(fa3), .o_fail_elem(fe3), .o_fail_data(fd3)
    );

    function automatic logic [7:0] faulty(input logic [7:0] d, input int a);
        logic [7:0] m;
        m = 8'b1 << f_bit;
        if (f_en && a == f_addr) return f_sa ? (d | m) : (d & ~m);
        return d;
    endfunction

    logic [7:0] mem1 [N];
    logic [7:0] mem3 [N];
    logic [7:0] rd1;
    logic [7:0] rq3 [3];

    always @(posedge clk) begin
        if (b1.write_enb) mem1[b1.address] <= faulty(b1.data_in, int'(b1.address));
        rd1 <= b1.read_enb ? mem1[b1.address] : 8'hA5;
        if (b3.write_enb) mem3[b3.address] <= faulty(b3.data_in, int'(b3.address));
        rq3[0] <= b3.read_enb ? mem3[b3.address] : 8'hA5;
        rq3[1] <= rq3[0];
        rq3[2] <= rq3[1];
    end
    assign b1.data_out = rd1;
    assign b3.data_out = rq3[2];

    logic          s_we, s_re, s_busy, s_done, s_pass;
    logic [AW-1:0] s_addr, s_fa;
    logic [2:0]    s_fe;
    logic [DW-1:0] s_din, s_fd;
    always_comb begin
        if (sel == 3) begin
            s_we = b3.write_enb; s_re = b3.read_enb; s_addr = b3.address;
            s_din = b3.data_in; s_busy = busy3; s_done = done3; s_pass = pass3;
            s_fa = fa3; s_fe = fe3; s_fd = fd3;
        end else begin
            s_we = b1.write_enb; s_re = b1.read_enb; s_addr = b1.address;
            s_din = b1.data_in; s_busy = busy1; s_done = done1; s_pass = pass1;
            s_fa = fa1; s_fe = fe1; s_fd = fd1;
        end
    end

    typedef struct { bit wr; int addr; int data; int elem; } op_t;
    op_t mq[$];

    typedef struct {
        bit fen; int fa; int fb; bit sa;
        bit ep; int ea; int ee; int ed;
    } vec_t;
    vec_t tv[5];

    int res_ops, res_ovl, res_trace, res_glitch, res_cyc;
    bit res_seen, res_pass, first_busy, first_done, first_pass;
    int res_fa, res_fe, res_fd, first_fa;

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: actual %0d required %0d", nm, act, exp);
        end
    endtask

    function automatic int all_out();
        return int'(s_busy | s_done | s_pass | (|s_fa) | (|s_fe) | (|s_fd) |
                    s_we | s_re | (|s_addr) | (|s_din));
    endfunction

    // March C- as a flat op list: (element, direction, read value, write value)
    function automatic void build_ops();
        int rdv[6];
        int wrv[6];
        int a;
        op_t o;
        rdv = '{-1, 0, 255, 0, 255, 0};
        wrv = '{0, 255, 0, 255, 0, -1};
        mq.delete();
        for (int e = 0; e < 6; e++) begin
            for (int j = 0; j < N; j++) begin
                a = (e == 3 || e == 4) ? N - 1 - j : j;
                if (rdv[e] >= 0) begin
                    o = '{1'b0, a, rdv[e], e};
                    mq.push_back(o);
                end
                if (wrv[e] >= 0) begin
                    o = '{1'b1, a, wrv[e], e};
                    mq.push_back(o);
                end
            end
        end
    endfunction

    task automatic predict(output bit ok, output int fa, output int fe,
                           output int fd, output int fi);
        int mem[N];
        int a;
        ok = 1'b1; fa = 0; fe = 0; fd = 0; fi = 0;
        for (int i = 0; i < mq.size(); i++) begin
            a = mq[i].addr;
            if (mq[i].wr)
                mem[a] = int'(faulty(8'(mq[i].data), a));
            else if (ok && mem[a] != mq[i].data) begin
                ok = 1'b0; fa = a; fe = mq[i].elem; fd = mem[a]; fi = i + 1;
            end
        end
    endtask

    task automatic set_start(input logic v);
        if (sel == 3) start3 = v; else start1 = v;
    endtask

    task automatic run_bist(input int repulse_at);
        int c;
        res_ops = 0; res_ovl = 0; res_trace = 0; res_glitch = 0; res_seen = 0;
        @(negedge clk); set_start(1'b1);
        @(negedge clk); set_start(1'b0);
        c = 1;
        first_busy = s_busy; first_done = s_done;
        first_pass = s_pass; first_fa = int'(s_fa);
        while (c < 12 * N) begin
            set_start(c == repulse_at);
            if (s_we && s_re) res_ovl++;
            if (!s_busy && (s_we || s_re || s_addr != 0 || s_din != 0)) res_glitch++;
            if (s_we || s_re) begin
                if (res_ops < mq.size()) begin
                    if (mq[res_ops].wr != s_we || mq[res_ops].addr != int'(s_addr) ||
                        (s_we && mq[res_ops].data != int'(s_din)))
                        res_trace++;
                end else
                    res_trace++;
                res_ops++;
            end
            if (s_done) begin
                res_seen = 1'b1;
                break;
            end
            @(negedge clk);
            c++;
        end
        set_start(1'b0);
        res_cyc = c; res_pass = s_pass;
        res_fa = int'(s_fa); res_fe = int'(s_fe); res_fd = int'(s_fd);
    endtask

    task automatic check_run(input string tag, input bit ep, input int ea,
                             input int ee, input int ed, input int fi, input int lat);
        int e_done, e_ops;
        e_done = (STOP && !ep) ? fi + 2 * lat + 1 : 10 * N + lat + 1;
        e_ops  = (STOP && !ep) ? fi + lat : 10 * N;
        chk({tag, "/done_seen"}, int'(res_seen), 1);
        chk({tag, "/done_cycle"}, res_cyc, e_done);
        chk({tag, "/pass"}, int'(res_pass), int'(ep));
        chk({tag, "/fail_addr"}, res_fa, ea);
        chk({tag, "/fail_elem"}, res_fe, ee);
        chk({tag, "/fail_data"}, res_fd, ed);
        chk({tag, "/op_count"}, res_ops, e_ops);
        chk({tag, "/overlap"}, res_ovl, 0);
        chk({tag, "/trace"}, res_trace, 0);
        chk({tag, "/idle_bus"}, res_glitch, 0);
        chk({tag, "/c1_busy"}, int'(first_busy), 1);
        chk({tag, "/c1_done"}, int'(first_done), 0);
        chk({tag, "/c1_pass"}, int'(first_pass), 0);
        chk({tag, "/c1_fail_addr"}, first_fa, 0);
    endtask

    initial begin
        bit ok;
        int pa, pe, pd, fi, c;
        tv[0] = '{1'b0, 0,     0, 1'b0, 1'b1, 0,     0, 0};
        tv[1] = '{1'b1, 'h2A,  3, 1'b0, 1'b0, 'h2A,  2, 'hF7};
        tv[2] = '{1'b1, 0,     0, 1'b1, 1'b0, 0,     1, 'h01};
        tv[3] = '{1'b1, 'h3F,  7, 1'b0, 1'b0, 'h3F,  2, 'h7F};
        tv[4] = '{1'b1, 'h15,  6, 1'b1, 1'b0, 'h15,  1, 'h40};

        rst = 1'b1; start1 = 1'b0; start3 = 1'b0; sel = 1;
        f_en = 1'b0; f_addr = 0; f_bit = 0; f_sa = 1'b0;
        build_ops();
        repeat (3) @(negedge clk);
        chk("reset_outputs_l1", all_out(), 0);
        sel = 3; #1;
        chk("reset_outputs_l3", all_out(), 0);
        sel = 1;
        rst = 1'b0;
        @(negedge clk);

        for (int v = 0; v < 5; v++) begin
            f_en = tv[v].fen; f_addr = tv[v].fa; f_bit = tv[v].fb; f_sa = tv[v].sa;
            predict(ok, pa, pe, pd, fi);
            run_bist(0);
            check_run($sformatf("vec%0d", v), tv[v].ep, tv[v].ea, tv[v].ee, tv[v].ed, fi, 1);
        end

        repeat (5) @(negedge clk);
        chk("done_held", int'(s_done), 1);
        chk("pass_held", int'(s_pass), 0);
        chk("fail_addr_held", int'(s_fa), 'h15);

        f_en = 1'b0;
        predict(ok, pa, pe, pd, fi);
        run_bist(100);
        check_run("repulse100", 1'b1, 0, 0, 0, fi, 1);

        for (int r = 0; r < 6; r++) begin
            f_en = 1'b1;
            f_addr = $urandom_range(0, N - 1);
            f_bit = $urandom_range(0, 7);
            f_sa = 1'($urandom_range(0, 1));
            predict(ok, pa, pe, pd, fi);
            run_bist(0);
            check_run($sformatf("rnd%0d", r), ok, pa, pe, pd, fi, 1);
        end

        f_en = 1'b0;
        @(negedge clk); start1 = 1'b1;
        @(negedge clk); start1 = 1'b0;
        c = 1;
        while (c < 300) begin
            @(negedge clk);
            c++;
        end
        chk("busy_at_300", int'(s_busy), 1);
        rst = 1'b1;
        @(negedge clk);
        chk("abort_outputs", all_out(), 0);
        rst = 1'b0;
        repeat (10) @(negedge clk);
        chk("abort_idle_busy", int'(s_busy), 0);
        chk("abort_idle_done", int'(s_done), 0);
        predict(ok, pa, pe, pd, fi);
        run_bist(0);
        check_run("after_abort", 1'b1, 0, 0, 0, fi, 1);

        sel = 3;
        f_en = 1'b0;
        predict(ok, pa, pe, pd, fi);
        run_bist(0);
        check_run("lat3_clean", 1'b1, 0, 0, 0, fi, 3);
        f_en = 1'b1; f_addr = 'h2A; f_bit = 3; f_sa = 1'b0;
        predict(ok, pa, pe, pd, fi);
        run_bist(0);
        check_run("lat3_2A", 1'b0, 'h2A, 2, 'hF7, fi, 3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
